// File: rtl/rng_sop_reader.sv
`default_nettype none
// ============================================================================
// Module   : rng_sop_reader
// Purpose  : Pops 128-bit RNG samples from the SOP port into a ping-pong
//            buffer and streams them out as 32-bit words (valid/ready).
// Revision : 1.0  initial release
// ============================================================================
module rng_sop_reader #(
  parameter int WORD_W = 32,
  parameter int SLOTS  = 2
) (
  input  logic                rng_clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                flush,
  input  logic                sop_valid,
  input  logic [4*WORD_W-1:0] sop_data,
  output logic                rd_sop,
  output logic [WORD_W-1:0]   rnd_word,
  output logic                rnd_word_valid,
  input  logic                rnd_word_ready,
  output logic [3:0]          words_avail,
  output logic                buf_full
);

  localparam int         SOP_W     = 4 * WORD_W;
  localparam int         PTR_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [1:0] LAST_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } fetch_state_e;

  fetch_state_e      state_q, state_d;
  logic              rd_sop_q, rd_sop_d;
  logic [SOP_W-1:0]  slot_q [SLOTS];
  logic [SOP_W-1:0]  slot_d [SLOTS];
  logic [SLOTS-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]        word_idx_q, word_idx_d;
  logic [WORD_W-1:0] rnd_word_q, rnd_word_d;
  logic              rnd_word_valid_q, rnd_word_valid_d;
  logic [3:0]        words_avail_q, words_avail_d;

  logic              w_cap;
  logic              w_xfer;
  logic              w_slot_free;
  logic              w_fetch_ok;
  logic [SOP_W-1:0]  w_head;

  assign w_cap       = rd_sop_q;
  assign w_xfer      = rnd_word_valid_q & rnd_word_ready;
  // Free-slot status comes from registered occupancy only, so rd_sop has
  // no combinational dependence on the current cycle's transfer.
  assign w_slot_free = ~occ_q[wr_ptr_q];
  assign w_fetch_ok  = enable & sop_valid & w_slot_free & ~flush;

  // Fetch FSM: a pop cycle is always followed by a gap cycle, giving the
  // producer one cycle to present its next sample.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_GAP: state_d = w_fetch_ok ? ST_POP : ST_IDLE;
      ST_POP:          state_d = ST_GAP;
      default:         state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = rd_sop_q ? ST_GAP : ST_IDLE;
    end
    rd_sop_d = (state_d == ST_POP);
  end

  // Buffer, word index and registered output stage.
  always_comb begin
    slot_d           = slot_q;
    occ_d            = occ_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    word_idx_d       = word_idx_q;
    rnd_word_d       = rnd_word_q;
    rnd_word_valid_d = rnd_word_valid_q;
    words_avail_d    = words_avail_q;
    w_head           = '0;

    if (w_xfer) begin
      if (word_idx_q == LAST_WORD) begin
        occ_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        word_idx_d      = 2'd0;
      end else begin
        word_idx_d = word_idx_q + 2'd1;
      end
    end

    // The pop was only granted into a free slot, and no other capture can
    // occur in between, so the write slot never collides with the head.
    if (w_cap) begin
      slot_d[wr_ptr_q] = sop_data;
      occ_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    words_avail_d = words_avail_q + (w_cap ? 4'd4 : 4'd0) - (w_xfer ? 4'd1 : 4'd0);

    w_head           = slot_d[rd_ptr_d];
    rnd_word_valid_d = occ_d[rd_ptr_d];
    if (rnd_word_valid_d) begin
      rnd_word_d = w_head[int'(word_idx_d) * WORD_W +: WORD_W];
    end

    if (flush) begin
      occ_d            = '0;
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
      word_idx_d       = 2'd0;
      words_avail_d    = 4'd0;
      rnd_word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      rd_sop_q         <= 1'b0;
      occ_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      word_idx_q       <= 2'd0;
      rnd_word_q       <= '0;
      rnd_word_valid_q <= 1'b0;
      words_avail_q    <= 4'd0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      rd_sop_q         <= rd_sop_d;
      occ_q            <= occ_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      word_idx_q       <= word_idx_d;
      rnd_word_q       <= rnd_word_d;
      rnd_word_valid_q <= rnd_word_valid_d;
      words_avail_q    <= words_avail_d;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign rd_sop         = rd_sop_q;
  assign rnd_word       = rnd_word_q;
  assign rnd_word_valid = rnd_word_valid_q;
  assign words_avail    = words_avail_q;
  assign buf_full       = &occ_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_sop_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_sop_reader
// Purpose  : Scoreboard bench: producer model feeds SOP, monitor checks words.
// Revision : 1.0  initial release
// ============================================================================
module tb_rng_sop_reader;

  logic         rng_clk = 1'b0;
  logic         rst_n, enable, flush, sop_valid, rnd_word_ready;
  logic [127:0] sop_data;
  logic         rd_sop, rnd_word_valid, buf_full;
  logic [31:0]  rnd_word;
  logic [3:0]   words_avail;

  always #5 rng_clk = ~rng_clk;

  rng_sop_reader #(.WORD_W(32), .SLOTS(2)) dut (
    .rng_clk        (rng_clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .sop_valid      (sop_valid),
    .sop_data       (sop_data),
    .rd_sop         (rd_sop),
    .rnd_word       (rnd_word),
    .rnd_word_valid (rnd_word_valid),
    .rnd_word_ready (rnd_word_ready),
    .words_avail    (words_avail),
    .buf_full       (buf_full)
  );

  int           errors = 0, checks = 0, cyc = 0, pulses = 0, delivered = 0;
  logic [127:0] prod_q [$];
  logic [31:0]  exp_q [$];
  int           pulse_cyc [$];
  logic         pop_pending = 1'b0, prev_rd = 1'b0;

  logic [31:0] w1  [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] wbp [8] = '{32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003,
                           32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [127:0] mk(input logic [15:0] tag);
    return {tag, 16'h0003, tag, 16'h0002, tag, 16'h0001, tag, 16'h0000};
  endfunction

  task automatic refresh();
    sop_valid = (prod_q.size() != 0);
    sop_data  = sop_valid ? prod_q[0] : '0;
  endtask

  task automatic add_sample(input logic [127:0] s);
    prod_q.push_back(s);
    refresh();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rng_clk);
    #2;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !rnd_word_valid; i++) tick(1);
    chk(name, rnd_word_valid, 1'b1);
  endtask

  task automatic wait_words(input string name, input int target, input int budget);
    for (int i = 0; i < budget && words_avail != 4'(target); i++) tick(1);
    chk(name, words_avail, target);
  endtask

  always @(posedge rng_clk) cyc++;

  // Producer: a popped sample is replaced just after the capturing edge.
  always @(posedge rng_clk) begin
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      if (prod_q.size() != 0) void'(prod_q.pop_front());
      refresh();
    end
  end

  // Monitor/scoreboard, sampled mid-cycle; models the coming edge afterwards.
  always @(negedge rng_clk) begin
    logic [127:0] s;
    if (!rst_n) begin
      exp_q.delete();
      pop_pending = 1'b0;
      prev_rd     = 1'b0;
    end else begin
      chk("mon_words_avail", words_avail, exp_q.size());
      chk("mon_valid", rnd_word_valid, exp_q.size() != 0);
      chk("mon_buf_full", buf_full, exp_q.size() > 4);
      if (rd_sop) begin
        chk("mon_rd_sop_adjacent", prev_rd, 1'b0);
        chk("mon_rd_sop_has_sample", prod_q.size() != 0, 1'b1);
        pulses++;
        pulse_cyc.push_back(cyc);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (rnd_word_valid && rnd_word_ready) begin
          delivered++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_word_unexpected: actual=%0h required=none", rnd_word);
          end else begin
            chk("mon_word", rnd_word, exp_q.pop_front());
          end
        end
        if (rd_sop && prod_q.size() != 0) begin
          s = prod_q[0];
          for (int k = 0; k < 4; k++) exp_q.push_back(s[32*k +: 32]);
        end
      end
      pop_pending = rd_sop;
      prev_rd     = rd_sop;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, p1, d0, r;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; rnd_word_ready = 1'b0;
    sop_valid = 1'b0; sop_data = '0;
    tick(1);
    chk("reset_rd_sop", rd_sop, 1'b0);
    chk("reset_word", rnd_word, 32'h0);
    chk("reset_valid", rnd_word_valid, 1'b0);
    chk("reset_avail", words_avail, 4'd0);
    chk("reset_full", buf_full, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Single sample
    enable = 1'b1; rnd_word_ready = 1'b1; p0 = pulses;
    add_sample(128'h44444444_33333333_22222222_11111111);
    wait_valid("single_wait", 10);
    chk("single_latency", cyc, pulse_cyc[$] + 1);
    for (int i = 0; i < 4; i++) begin
      chk("single_word", rnd_word, w1[i]);
      chk("single_avail", words_avail, 4 - i);
      chk("single_valid", rnd_word_valid, 1'b1);
      tick(1);
    end
    chk("single_end_valid", rnd_word_valid, 1'b0);
    chk("single_end_avail", words_avail, 4'd0);
    chk("single_pulses", pulses - p0, 1);

    // Back-pressure until full, then release
    rnd_word_ready = 1'b0; p0 = pulses;
    add_sample(mk(16'hB000)); add_sample(mk(16'hC000)); add_sample(mk(16'hD000));
    tick(8);
    chk("bp_pulses", pulses - p0, 2);
    chk("bp_spacing", pulse_cyc[$] - pulse_cyc[$-1], 2);
    chk("bp_full", buf_full, 1'b1);
    chk("bp_avail", words_avail, 4'd8);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_word", rnd_word, 32'hB0000000);
      tick(1);
    end
    chk("bp_no_more_rd_sop", pulses - p0, 2);
    rnd_word_ready = 1'b1; r = cyc;
    for (int i = 0; i < 8; i++) begin
      chk("bp_word", rnd_word, wbp[i]);
      chk("bp_no_bubble", rnd_word_valid, 1'b1);
      tick(1);
    end
    chk("bp_third_pulse", pulses - p0, 3);
    chk("bp_third_time", pulse_cyc[$], r + 5);
    wait_words("bp_drain", 0, 20);

    // Continuous stream, then enable drop while draining
    p0 = pulses; d0 = delivered;
    for (int i = 0; i < 20; i++) add_sample(mk(16'h5A00 + 16'(i)));
    tick(40);
    enable = 1'b0;
    tick(3);
    p1 = pulses;
    wait_words("stream_drain", 0, 40);
    tick(6);
    chk("en_off_no_rd_sop", pulses, p1);
    chk("stream_words", delivered - d0, 4 * (pulses - p0));
    chk("stream_min_pulses", (pulses - p0) >= 8, 1'b1);
    prod_q.delete();
    refresh();

    // Capture and transfer in the same cycle at words_avail=2
    enable = 1'b1; rnd_word_ready = 1'b0;
    add_sample(mk(16'hE000));
    wait_words("cx_fill", 4, 10);
    rnd_word_ready = 1'b1;
    tick(2);
    rnd_word_ready = 1'b0;
    chk("cx_at_two", words_avail, 4'd2);
    add_sample(mk(16'hF000));
    tick(1);
    chk("cx_rd_sop", rd_sop, 1'b1);
    rnd_word_ready = 1'b1;
    tick(1);
    chk("cx_avail_five", words_avail, 4'd5);
    rnd_word_ready = 1'b0;

    // Asynchronous reset with five words held
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_sop", rd_sop, 1'b0);
    chk("rst_word", rnd_word, 32'h0);
    chk("rst_valid", rnd_word_valid, 1'b0);
    chk("rst_avail", words_avail, 4'd0);
    chk("rst_full", buf_full, 1'b0);
    @(posedge rng_clk);
    #2 rst_n = 1'b1;
    tick(1);
    add_sample(mk(16'h7777));
    wait_valid("post_reset_wait", 10);
    chk("post_reset_word", rnd_word, 32'h77770000);
    chk("post_reset_avail", words_avail, 4'd4);
    rnd_word_ready = 1'b1;
    wait_words("post_reset_drain", 0, 10);

    // Flush coinciding with rd_sop
    rnd_word_ready = 1'b0;
    add_sample(mk(16'h8888));
    wait_words("fl_fill", 4, 10);
    rnd_word_ready = 1'b1;
    tick(2);
    rnd_word_ready = 1'b0;
    chk("fl_at_two", words_avail, 4'd2);
    add_sample(mk(16'h9999)); add_sample(mk(16'hAAAA));
    tick(1);
    chk("fl_rd_sop", rd_sop, 1'b1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("fl_avail_zero", words_avail, 4'd0);
    chk("fl_valid_zero", rnd_word_valid, 1'b0);
    chk("fl_no_rd_sop", rd_sop, 1'b0);
    rnd_word_ready = 1'b1;
    wait_valid("fl_resume_wait", 10);
    chk("fl_resume_word", rnd_word, 32'hAAAA0000);
    wait_words("fl_drain", 0, 10);

    tick(2);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
